// File: rtl/mul_accum_stage.sv
// Accumulates a group of multiplier products into a wide sum.
// Products arrive and the sum leaves over valid/ready handshakes.
`timescale 1ns/1ps

module mul_accum_stage #(
  parameter int PW = 64,
  parameter int LW = 8,
  parameter int AW = 72
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic          prod_valid,
  input  logic [PW-1:0] prod,
  output logic          prod_ready,
  output logic          sum_valid,
  output logic [AW-1:0] sum,
  input  logic          sum_ready,
  output logic [LW-1:0] count,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        r_state;
  logic [AW-1:0] r_acc;
  logic [AW-1:0] r_sum;
  logic [LW-1:0] r_count;
  logic [LW-1:0] r_len;
  logic          r_sumValid;

  logic          w_accept;
  logic          w_lastTerm;
  logic [AW-1:0] w_accNext;

  assign prod_ready = (r_state == ACC);
  assign busy       = (r_state != IDLE);
  assign sum_valid  = r_sumValid;
  assign sum        = r_sum;
  assign count      = r_count;

  assign w_accept   = prod_valid & prod_ready;
  assign w_lastTerm = ((r_count + LW'(1)) == r_len);
  assign w_accNext  = r_acc + {{(AW-PW){1'b0}}, prod};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_sum      <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_sumValid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start && (len != '0)) begin
            r_len   <= len;
            r_acc   <= '0;
            r_count <= '0;
            r_state <= ACC;
          end
        end
        ACC: begin
          if (w_accept) begin
            r_acc   <= w_accNext;
            r_count <= r_count + LW'(1);
            // The final sum includes the term arriving on this same edge.
            if (w_lastTerm) begin
              r_sum      <= w_accNext;
              r_sumValid <= 1'b1;
              r_state    <= DONE;
            end
          end
        end
        DONE: begin
          if (sum_ready) begin
            r_sumValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_accum_stage.md
Name: mul_accum_stage

Overview:
- Downstream consumer of the 32x32 pipelined Wallace multiplier's 64-bit product.
- Accepts products over a valid/ready handshake and accumulates a group of `len` products into a wide sum.
- Presents the finished sum on an output valid/ready handshake, with backpressure.
- Used for dot-product and multiply-accumulate sequences built on the multiplier.

Parameters:
- PW, 64, product input width (matches multiplier output).
- LW, 8, width of group-length input and term counter.
- AW, 72, accumulator/sum width; AW = PW + LW, so no overflow is possible.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin a new group; sampled in IDLE only.
- len  input  LW  number of products in the group; sampled with start.
- prod_valid  input  1  prod holds a valid product.
- prod  input  PW  unsigned product from the multiplier.
- prod_ready  output  1  block accepts prod this cycle.
- sum_valid  output  1  sum holds a completed group result.
- sum  output  AW  unsigned accumulated result.
- sum_ready  input  1  consumer takes sum this cycle.
- count  output  LW  products accepted so far in the current group.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: when reset==0 at a clk edge, the following are cleared:
  - state=IDLE
  - accumulator, sum, count, latched len = 0
  - prod_ready=0, sum_valid=0, busy=0
- Reset mid-group discards the partial sum; no output is produced for that group.
- States are IDLE, ACC and DONE. prod_ready and busy are registered/decoded from state, never combinationally from inputs.
- IDLE:
  - prod_ready=0.
  - start=1 with len!=0: latch len, clear accumulator and count, go to ACC.
  - start=1 with len==0: ignored, stay in IDLE.
- ACC:
  - prod_ready=1.
  - Accept occurs when prod_valid & prod_ready. On accept: accumulator += zero-extended prod, count += 1.
  - If the accept is the last term (count+1 == latched len):
    - sum <= accumulator + prod, computed in the same edge.
    - sum_valid <= 1.
    - go to DONE.
  - Latency: sum_valid is high in the cycle after the last accept.
  - Idle prod_valid cycles (gaps) are allowed and do not change state.
  - start is ignored in ACC.
- DONE:
  - prod_ready=0; prod_valid is ignored.
  - sum and sum_valid are held stable until sum_valid & sum_ready.
  - On that handshake: sum_valid <= 0, go to IDLE.
  - sum keeps its last value after the handshake; only sum_valid qualifies it.
  - start in DONE is ignored, including in the handshake cycle; it must be reissued in IDLE.
- count output: equals the number of accepts in the current group; holds len while in DONE; cleared on start.
- Arithmetic: unsigned only; no saturation needed because at most 255 terms of 2^64-1 fit in 72 bits.
- Throughput: one product per cycle in ACC. Minimum gap between groups is 2 cycles (DONE handshake, then IDLE start).

Test Plan:
- Basic group: reset low 2 cycles, then high. start, len=3. Products 121, 123321, 123444321 on consecutive cycles. Expected: prod_ready=1 for exactly those 3 cycles; sum_valid rises the next cycle with sum=123567763; count=3.
- Backpressure: repeat the basic group with sum_ready=0 for 5 cycles after sum_valid. Expected:
  - sum and sum_valid stable throughout; prod_ready=0.
  - prod_valid pulses in that window are not accepted.
  - When sum_ready=1: one transfer occurs, then sum_valid=0 and busy=0.
- Maximum width: len=255, prod=64'hFFFF_FFFF_FFFF_FFFF every cycle. Expected: sum=72'hFE_FFFF_FFFF_FFFF_FF01 after 255 accepts; count=255; no wrap.
- Ignored starts and gaps:
  - start with len=0 in IDLE: busy stays 0.
  - Group len=4 with prod_valid toggling every other cycle: count increments only on accepts.
  - A start pulse asserted during ACC: no effect.
  - Products 1,2,3,4 give sum=10.
- Reset mid-operation: len=4 group, reset low for 1 cycle after 2 accepts. Expected:
  - Next cycle: all outputs 0, state IDLE.
  - A new group with len=1, prod=168846 (789*214) gives sum=168846, not including stale terms.
- Back-to-back groups: sum_ready held high. Expected:
  - Group1 len=2 (5, 7) gives sum=12.
  - start in the cycle after the DONE handshake; group2 len=1 (9) gives sum=9.
  - No lost or duplicated sum_valid pulses.
